// File: rtl/frame_scheduler_pkg.sv
// rtl/frame_scheduler_pkg.sv - shared types, widths and helpers for the frame scheduler
// Purpose: state enum, framebuffer/colour/coordinate widths, default clear
//          colour and the constant-multiply helper used for address generation.
// Ports:   none (package).
package frame_scheduler_pkg;

  localparam int FB_ADDR_W = 20;
  localparam int COLOR_W   = 16;
  localparam int COORD_W   = 10;
  localparam int LIN_W     = FB_ADDR_W - 1;

  localparam logic [COLOR_W-1:0] DEFAULT_CLEAR_COLOR = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR_REQ,
    ST_CLR,
    ST_CLR_REL,
    ST_DRW_REQ,
    ST_DRW,
    ST_DRW_REL,
    ST_WAIT_VS
  } sched_state_e;

  // y * k built only from shifted copies of y, one per set bit of the
  // elaboration-time constant k (640 -> y<<9 + y<<7). Result wraps to LIN_W.
  function automatic logic [LIN_W-1:0] mul_shift_add(input logic [COORD_W-1:0] y,
                                                     input logic [31:0] k);
    logic [LIN_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (k[i]) acc = acc + (LIN_W'(y) << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/frame_scheduler_if.sv
// rtl/frame_scheduler_if.sv - engine handshakes and framebuffer write port bundle
// Purpose: groups the clear-engine, draw-engine and framebuffer write signals.
// Ports:   master = scheduler (drives starts and fb write), slave = engines/fb side.
interface frame_scheduler_if;
  import frame_scheduler_pkg::*;

  logic                 clear_start;
  logic                 clear_done;
  logic [COORD_W-1:0]   clear_x;
  logic [COORD_W-1:0]   clear_y;

  logic                 draw_start;
  logic                 draw_done;
  logic [COORD_W-1:0]   draw_x;
  logic [COORD_W-1:0]   draw_y;
  logic [COLOR_W-1:0]   draw_color;
  logic                 draw_we;

  logic [FB_ADDR_W-1:0] fb_addr;
  logic [COLOR_W-1:0]   fb_data;
  logic                 fb_we;

  modport master (
    output clear_start, draw_start, fb_addr, fb_data, fb_we,
    input  clear_done, clear_x, clear_y,
    input  draw_done, draw_x, draw_y, draw_color, draw_we
  );

  modport slave (
    input  clear_start, draw_start, fb_addr, fb_data, fb_we,
    output clear_done, clear_x, clear_y,
    output draw_done, draw_x, draw_y, draw_color, draw_we
  );

endinterface

// File: rtl/fb_addr_gen.sv
// rtl/fb_addr_gen.sv - pixel coordinate to framebuffer address with range check
// Purpose: addr_o = {buf_i, y*H_TOTAL + x} truncated to LIN_W bits; in_range_o
//          is high only when (x,y) lies inside H_TOTAL x V_TOTAL.
// Ports:   x_i, y_i (coordinates), buf_i (buffer select), addr_o, in_range_o.
module fb_addr_gen
  import frame_scheduler_pkg::*;
#(
  parameter int H_TOTAL = 640,
  parameter int V_TOTAL = 480
) (
  input  logic [COORD_W-1:0]   x_i,
  input  logic [COORD_W-1:0]   y_i,
  input  logic                 buf_i,
  output logic [FB_ADDR_W-1:0] addr_o,
  output logic                 in_range_o
);

  logic [LIN_W-1:0] lin;

  always_comb begin
    lin        = mul_shift_add(y_i, 32'(H_TOTAL)) + LIN_W'(x_i);
    in_range_o = ({22'd0, x_i} < 32'(H_TOTAL)) && ({22'd0, y_i} < 32'(V_TOTAL));
    addr_o     = {buf_i, lin};
  end

endmodule

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - double-buffered clear/draw/swap sequencer
// Purpose: per frame, runs the clear engine then the draw engine into the back
//          buffer, then waits for a VS falling edge to swap buffers. A VS edge
//          arriving before the work is done sets the sticky frame_drop flag.
// Ports:   clk, rst (async active-high), vs_i (active-low vsync),
//          bus (engine handshakes + fb write port, master side),
//          front_buf_o, frame_count_o, frame_drop_o.
module frame_scheduler
  import frame_scheduler_pkg::*;
#(
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = DEFAULT_CLEAR_COLOR,
  parameter int                 H_TOTAL     = 640,
  parameter int                 V_TOTAL     = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vs_i,
  frame_scheduler_if.master     bus,
  output logic                  front_buf_o,
  output logic [7:0]            frame_count_o,
  output logic                  frame_drop_o
);

  sched_state_e state_q, state_d;
  logic         front_q, front_d;
  logic [7:0]   count_q, count_d;
  logic         drop_q, drop_d;
  logic         vs_q1, vs_q2;
  logic         boundary;

  logic               sel_draw;
  logic               wr_req;
  logic               addr_active;
  logic [COLOR_W-1:0] data_c;
  logic [COORD_W-1:0] src_x, src_y;
  logic [FB_ADDR_W-1:0] gen_addr;
  logic               gen_in_range;

  // vs_q2 is the older sample: high then low means VS has just fallen.
  assign boundary = vs_q2 & ~vs_q1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      front_q <= 1'b0;
      count_q <= 8'd0;
      drop_q  <= 1'b0;
      vs_q1   <= 1'b1;
      vs_q2   <= 1'b1;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      vs_q1   <= vs_i;
      vs_q2   <= vs_q1;
    end
  end

  always_comb begin
    state_d         = state_q;
    front_d         = front_q;
    count_d         = count_q;
    drop_d          = drop_q | (boundary & (state_q != ST_WAIT_VS));
    bus.clear_start = 1'b0;
    bus.draw_start  = 1'b0;
    sel_draw        = 1'b0;
    wr_req          = 1'b0;
    addr_active     = 1'b0;
    data_c          = '0;

    case (state_q)
      ST_IDLE: state_d = ST_CLR_REQ;
      ST_CLR_REQ: begin
        bus.clear_start = 1'b1;
        state_d         = ST_CLR;
      end
      ST_CLR: begin
        bus.clear_start = 1'b1;
        addr_active     = 1'b1;
        data_c          = CLEAR_COLOR;
        wr_req          = ~bus.clear_done;
        if (bus.clear_done) state_d = ST_CLR_REL;
      end
      ST_CLR_REL: begin
        if (!bus.clear_done) state_d = ST_DRW_REQ;
      end
      ST_DRW_REQ: begin
        bus.draw_start = 1'b1;
        state_d        = ST_DRW;
      end
      ST_DRW: begin
        bus.draw_start = 1'b1;
        sel_draw       = 1'b1;
        addr_active    = 1'b1;
        data_c         = bus.draw_color;
        wr_req         = bus.draw_we & ~bus.draw_done;
        if (bus.draw_done) state_d = ST_DRW_REL;
      end
      ST_DRW_REL: begin
        if (!bus.draw_done) state_d = ST_WAIT_VS;
      end
      ST_WAIT_VS: begin
        if (boundary) begin
          front_d = ~front_q;
          count_d = count_q + 8'd1;
          state_d = ST_CLR_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign src_x = sel_draw ? bus.draw_x : bus.clear_x;
  assign src_y = sel_draw ? bus.draw_y : bus.clear_y;

  fb_addr_gen #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_addr_gen (
    .x_i        (src_x),
    .y_i        (src_y),
    .buf_i      (~front_q),
    .addr_o     (gen_addr),
    .in_range_o (gen_in_range)
  );

  // Off-screen coordinates are silently dropped rather than wrapped.
  assign bus.fb_we   = wr_req & gen_in_range;
  assign bus.fb_addr = addr_active ? gen_addr : '0;
  assign bus.fb_data = data_c;

  assign front_buf_o   = front_q;
  assign frame_count_o = count_q;
  assign frame_drop_o  = drop_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// tb/tb_frame_scheduler.sv - self-checking bench for frame_scheduler
module tb_frame_scheduler;
  import frame_scheduler_pkg::*;

  localparam int H    = 40;
  localparam int V    = 6;
  localparam int NPIX = H * V;
  localparam logic [15:0] CC = 16'h1234;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vs  = 1'b1;
  logic       front;
  logic [7:0] fcount;
  logic       fdrop;

  frame_scheduler_if bus ();

  frame_scheduler #(
    .CLEAR_COLOR (CC),
    .H_TOTAL     (H),
    .V_TOTAL     (V)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .vs_i          (vs),
    .bus           (bus),
    .front_buf_o   (front),
    .frame_count_o (fcount),
    .frame_drop_o  (fdrop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [19:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    int          x;
    int          y;
    logic [15:0] c;
    bit          we;
  } item_t;

  wr_t        exp_q[$];
  item_t      items[$];
  logic       exp_front = 1'b0;
  logic [7:0] exp_count = 8'd0;
  logic       exp_drop  = 1'b0;
  int         checks    = 0;
  int         errors    = 0;
  int         wr_count  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [19:0] exp_addr(input int x, input int y);
    logic [18:0] l;
    l = 19'(y * H + x);
    return {~exp_front, l};
  endfunction

  // Every cycle: buffer state against the model, and each fb write against the
  // ordered list of writes the engines were expected to cause.
  always @(negedge clk) begin
    wr_t w;
    chk("front_buf", {31'd0, front}, {31'd0, exp_front});
    chk("frame_count", {24'd0, fcount}, {24'd0, exp_count});
    chk("frame_drop", {31'd0, fdrop}, {31'd0, exp_drop});
    if (bus.fb_we === 1'b1) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual addr %0h required no write", bus.fb_addr);
      end else begin
        w = exp_q.pop_front();
        chk("wr_addr", {12'd0, bus.fb_addr}, {12'd0, w.addr});
        chk("wr_data", {16'd0, bus.fb_data}, {16'd0, w.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input int abort_at);
    int n;
    int base;
    n = 0;
    while (bus.clear_start !== 1'b1 && n < 50) begin tick(); n++; end
    chk("clear_start_seen", {31'd0, bus.clear_start}, 32'd1);
    if (bus.clear_start !== 1'b1) return;
    tick();
    base = wr_count;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        if (y * H + x == abort_at) begin
          rst = 1'b1;
          exp_front = 1'b0; exp_count = 8'd0; exp_drop = 1'b0;
          exp_q.delete();
          #1;
          chk("rst_clear_start", {31'd0, bus.clear_start}, 32'd0);
          chk("rst_fb_we", {31'd0, bus.fb_we}, 32'd0);
          chk("rst_fb_addr", {12'd0, bus.fb_addr}, 32'd0);
          chk("rst_count", {24'd0, fcount}, 32'd0);
          bus.clear_x = '0; bus.clear_y = '0; bus.clear_done = 1'b0;
          tick(); tick(); tick();
          rst = 1'b0;
          return;
        end
        bus.clear_x = 10'(x);
        bus.clear_y = 10'(y);
        exp_q.push_back({exp_addr(x, y), CC});
        #1;
        if (x == 0 && y == 0)
          chk("clear_first_addr", {12'd0, bus.fb_addr}, exp_front ? 32'h00000 : 32'h80000);
        if (x == H - 1 && y == V - 1)
          chk("clear_last_addr", {12'd0, bus.fb_addr}, exp_front ? 32'd239 : 32'h80000 + 32'd239);
        tick();
      end
    end
    bus.clear_done = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus.clear_start !== 1'b0 && n < 50);
    chk("clear_release", {31'd0, bus.clear_start}, 32'd0);
    bus.clear_done = 1'b0;
    chk("clear_write_count", wr_count - base, 32'd240);
    chk("clear_pending", exp_q.size(), 32'd0);
  endtask

  task automatic do_draw(input int drop_at, input bit literal_frame);
    int n;
    n = 0;
    while (bus.draw_start !== 1'b1 && n < 50) begin tick(); n++; end
    chk("draw_start_seen", {31'd0, bus.draw_start}, 32'd1);
    if (bus.draw_start !== 1'b1) return;
    tick();
    for (int i = 0; i < items.size(); i++) begin
      if (drop_at >= 0 && i == drop_at + 2) begin
        exp_drop = 1'b1;
        vs = 1'b1;
      end
      bus.draw_x     = 10'(items[i].x);
      bus.draw_y     = 10'(items[i].y);
      bus.draw_color = items[i].c;
      bus.draw_we    = items[i].we;
      if (items[i].we && items[i].x < H && items[i].y < V)
        exp_q.push_back({exp_addr(items[i].x, items[i].y), items[i].c});
      #1;
      if (i == drop_at) vs = 1'b0;
      if (literal_frame && i == 0) begin
        chk("draw_lit_we", {31'd0, bus.fb_we}, 32'd1);
        chk("draw_lit_addr", {12'd0, bus.fb_addr}, 32'h8005A);
        chk("draw_lit_data", {16'd0, bus.fb_data}, 32'hF800);
      end
      if (literal_frame && i == 1) chk("draw_x700_we", {31'd0, bus.fb_we}, 32'd0);
      tick();
    end
    bus.draw_done = 1'b1;
    bus.draw_we   = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.draw_start !== 1'b0 && n < 50);
    chk("draw_release", {31'd0, bus.draw_start}, 32'd0);
    bus.draw_done = 1'b0;
    chk("draw_pending", exp_q.size(), 32'd0);
  endtask

  task automatic wait_idle(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      tick();
      chk("wait_no_clear_start", {31'd0, bus.clear_start}, 32'd0);
    end
  endtask

  task automatic swap();
    vs = 1'b0;
    tick();
    tick();
    exp_front = ~exp_front;
    exp_count = exp_count + 8'd1;
    vs = 1'b1;
    chk("clear_start_after_swap", {31'd0, bus.clear_start}, 32'd1);
  endtask

  task automatic random_items();
    item_t it;
    int n;
    items.delete();
    n = $urandom_range(3, 8);
    for (int i = 0; i < n; i++) begin
      it.x  = $urandom_range(0, 45);
      it.y  = $urandom_range(0, 7);
      it.c  = 16'($urandom);
      it.we = 1'($urandom_range(0, 1));
      items.push_back(it);
    end
  endtask

  task automatic frame(input bit literal_frame, input int drop_at);
    do_clear(-1);
    do_draw(drop_at, literal_frame);
    wait_idle($urandom_range(0, 4));
    swap();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    bus.clear_done = 1'b0; bus.clear_x = '0; bus.clear_y = '0;
    bus.draw_done = 1'b0; bus.draw_x = '0; bus.draw_y = '0;
    bus.draw_color = '0; bus.draw_we = 1'b0;

    tick(); tick(); tick();
    chk("reset_clear_start", {31'd0, bus.clear_start}, 32'd0);
    chk("reset_draw_start", {31'd0, bus.draw_start}, 32'd0);
    chk("reset_fb_we", {31'd0, bus.fb_we}, 32'd0);
    chk("reset_fb_addr", {12'd0, bus.fb_addr}, 32'd0);
    chk("reset_fb_data", {16'd0, bus.fb_data}, 32'd0);
    rst = 1'b0;
    tick();
    chk("clear_start_cycle1", {31'd0, bus.clear_start}, 32'd1);

    items.delete();
    items.push_back('{10, 2, 16'hF800, 1'b1});
    items.push_back('{700, 3, 16'h07E0, 1'b1});
    items.push_back('{5, 5, 16'h001F, 1'b0});
    items.push_back('{39, 5, 16'hABCD, 1'b1});
    items.push_back('{40, 0, 16'h1111, 1'b1});
    items.push_back('{0, 6, 16'h2222, 1'b1});
    frame(1'b1, -1);
    chk("count_after_first_swap", {24'd0, fcount}, 32'd1);
    chk("front_after_first_swap", {31'd0, front}, 32'd1);

    items.delete();
    for (int i = 0; i < 6; i++) items.push_back('{i * 7, i, 16'(16'h0100 + i), 1'b1});
    frame(1'b0, 1);
    chk("drop_sticky", {31'd0, fdrop}, 32'd1);
    chk("count_after_drop_frame", {24'd0, fcount}, 32'd2);

    for (int f = 0; f < 3; f++) begin
      random_items();
      d = (items.size() >= 5 && $urandom_range(0, 1) == 1) ? $urandom_range(0, items.size() - 3) : -1;
      frame(1'b0, d);
    end

    do_clear(17);
    tick();
    chk("restart_clear_start", {31'd0, bus.clear_start}, 32'd1);
    random_items();
    frame(1'b0, -1);
    chk("count_after_reset_frame", {24'd0, fcount}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter CLEAR_COLOR, default 16'h0000, pixel value written by every clear write.
REQ-002 Parameter H_TOTAL, default 640, frame width in pixels; V_TOTAL, default 480, frame height.
REQ-003 Clk  input  1  single clock; all state on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 VS  input  1  VGA vertical sync, active-low; its falling edge marks a frame boundary.
REQ-006 clear_start, output, 1: level request to the frame-clear engine. clear_done, input, 1: clear-engine completion level.
REQ-007 clear_x, clear_y, inputs, 10 each: current clear pixel from the clear engine.
REQ-008 draw_start, output, 1: level request to the draw engine. draw_done, input, 1: draw-engine completion level.
REQ-009 draw_x, draw_y, inputs, 10 each; draw_color, input, 16; draw_we, input, 1: draw engine pixel write.
REQ-010 fb_addr, output, 20: {back buffer bit, y*H_TOTAL+x} as 1+19 bits. fb_data, output, 16. fb_we, output, 1.
REQ-011 front_buf, output, 1: buffer index the display reads; back buffer = ~front_buf.
REQ-012 frame_count, output, 8: completed swaps, wraps 255->0. frame_drop, output, 1: sticky overrun flag.

Function
REQ-013 FSM states: IDLE, CLR_REQ, CLR, CLR_REL, DRW_REQ, DRW, DRW_REL, WAIT_VS.
REQ-014 IDLE -> CLR_REQ unconditionally on the first cycle after reset release.
REQ-015 CLR_REQ: clear_start=1, fb_we=0; -> CLR next cycle.
REQ-016 CLR: clear_start=1; fb_we = ~clear_done; fb_data = CLEAR_COLOR; address from clear_x/clear_y; -> CLR_REL when clear_done=1.
REQ-017 CLR_REL: clear_start=0, fb_we=0; -> DRW_REQ when clear_done=0.
REQ-018 DRW_REQ/DRW/DRW_REL mirror REQ-015..017 with draw_start/draw_done; in DRW, fb_we = draw_we & ~draw_done, data draw_color, address from draw_x/draw_y; DRW_REL -> WAIT_VS.
REQ-019 A full clear produces exactly H_TOTAL*V_TOTAL fb_we cycles, row-major from (0,0) to (H_TOTAL-1,V_TOTAL-1).
REQ-020 Frame boundary = VS registered twice, 1->0 transition; detection latency 2 cycles after VS falls.
REQ-021 WAIT_VS on boundary: front_buf toggles, frame_count increments, -> CLR_REQ; both take effect the same cycle.
REQ-022 Boundary in any state other than WAIT_VS: frame_drop set to 1 (sticky until reset), no swap, no count; sequence continues.
REQ-023 fb_addr computed combinationally from current state and source coordinates; fb_we=0 in all states not listed as writing.
REQ-024 Coordinates outside H_TOTAL x V_TOTAL while writing: fb_we forced to 0.
REQ-025 fb_addr multiply done by shift-add (y<<9 + y<<7 for 640); truncated to 19 bits.

Reset
REQ-026 Reset asserted: state IDLE, front_buf=0, frame_count=0, frame_drop=0, VS sync registers=1, all outputs 0.
REQ-027 Reset mid-clear or mid-draw: outputs drop to 0 asynchronously; engines are released and complete their own return to idle.

Structure
REQ-028 Shared package holds the state enum type, FB_ADDR_W=20, COLOR_W=16 and default CLEAR_COLOR.
REQ-029 One sub-module, fb_addr_gen: combinational (x,y,buf) -> fb_addr with range check.

Verification
REQ-030 Reset release with clear-engine model -> clear_start high cycle 1; 307200 fb_we pulses, first addr 0x80000 (back=1), last 0x80000+307199.
REQ-031 Draw model writes (10,2) color 16'hF800 -> fb_we one cycle, fb_addr 0x80000+1290, fb_data F800.
REQ-032 Draw done then VS falls -> 2 cycles later front_buf=1, frame_count=1, clear_start rises next cycle, writes now target buffer 0.
REQ-033 VS falls while in DRW -> frame_drop=1, front_buf unchanged, swap only at next boundary after draw completes.
REQ-034 Draw model emits draw_x=700 with draw_we=1 -> fb_we stays 0.
REQ-035 Reset pulsed mid-CLR -> all outputs 0 same cycle; after release sequence restarts from CLR_REQ with frame_count=0.
